// File: rtl/demorgan_sweep_ctrl_pkg.sv
// Shared types, record layout and golden model for the De Morgan sweep
// controller.
package demorgan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_EMIT,
    S_DONE
  } state_e;

  localparam int VEC_COUNT = 4;

  localparam int REC_A      = 7;
  localparam int REC_B      = 6;
  localparam int REC_NA     = 5;
  localparam int REC_NB     = 4;
  localparam int REC_NANB   = 3;
  localparam int REC_NAORNB = 2;
  localparam int REC_AB     = 1;
  localparam int REC_AORB   = 0;

  // Expected {na,nb,nanb,naornb,ab,aorb} for one input vector.
  function automatic logic [5:0] demorgan_golden(
    input logic a,
    input logic b
  );
    return {~a, ~b, ~a & ~b, ~a | ~b,
            ~(a & b), ~(a | b)};
  endfunction

endpackage

// File: rtl/demorgan_sweep_ctrl_if.sv
// Result-record stream: one record per
// swept vector, valid/ready handshake.
interface demorgan_sweep_ctrl_if;

  logic       rec_valid;
  logic       rec_ready;
  logic [7:0] rec_data;
  logic       rec_mismatch;

  modport master (
    output rec_valid,
    output rec_data,
    output rec_mismatch,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_data,
    input  rec_mismatch,
    output rec_ready
  );

endinterface

// File: rtl/demorgan_sweep_ctrl.sv
// Drives every (A,B) vector into the De Morgan datapath, samples the six
// outputs, and streams a checked result record per vector.
module demorgan_sweep_ctrl
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [ERR_W-1:0] err_count,
  output logic             a_out,
  output logic             b_out,
  input  logic             na_in,
  input  logic             nb_in,
  input  logic             nanb_in,
  input  logic             naornb_in,
  input  logic             ab_in,
  input  logic             aorb_in,
  demorgan_sweep_ctrl_if.master rec
);

  localparam int SET_W =
    SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PAS_W =
    NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;

  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PAS_W-1:0] PAS_LAST =
    PAS_W'(NUM_PASSES - 1);
  localparam logic [1:0] VEC_LAST =
    2'(VEC_COUNT - 1);

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [PAS_W-1:0] pass_q, pass_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ap_q, ap_d;
  logic [7:0]       rec_q, rec_d;
  logic             mis_q, mis_d;

  logic [7:0]       smp;
  logic             smp_mis;

  always_comb begin
    smp             = '0;
    smp[REC_A]      = a_q;
    smp[REC_B]      = b_q;
    smp[REC_NA]     = na_in;
    smp[REC_NB]     = nb_in;
    smp[REC_NANB]   = nanb_in;
    smp[REC_NAORNB] = naornb_in;
    smp[REC_AB]     = ab_in;
    smp[REC_AORB]   = aorb_in;
    // 4-state compare so X/Z from the datapath flags a mismatch
    smp_mis = (smp[5:0] !== demorgan_golden(a_q, b_q));
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    set_d   = set_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    ap_d    = ap_q;
    rec_d   = rec_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = '0;
          ap_d    = 1'b0;
          vec_d   = '0;
          pass_d  = '0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        a_d     = vec_q[1];
        b_d     = vec_q[0];
        set_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (set_q == SET_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      S_SAMPLE: begin
        rec_d = smp;
        mis_d = smp_mis;
        if (smp_mis && (err_q != '1)) begin
          err_d = err_q + ERR_W'(1);
        end
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (rec.rec_ready) begin
          if (vec_q != VEC_LAST) begin
            vec_d   = vec_q + 2'd1;
            state_d = S_DRIVE;
          end else if (pass_q != PAS_LAST) begin
            vec_d   = '0;
            pass_d  = pass_q + PAS_W'(1);
            state_d = S_DRIVE;
          end else begin
            // err_q is final here, so all_pass is valid with done
            ap_d    = (err_q == '0);
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      pass_q  <= '0;
      set_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      ap_q    <= 1'b0;
      rec_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
      set_q   <= set_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      ap_q    <= ap_d;
      rec_q   <= rec_d;
      mis_q   <= mis_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign all_pass         = ap_q;
  assign err_count        = err_q;
  assign a_out            = a_q;
  assign b_out            = b_q;
  assign rec.rec_valid    = (state_q == S_EMIT);
  assign rec.rec_data     = rec_q;
  assign rec.rec_mismatch = mis_q;

endmodule
